shift_sequencer: RTL and testbench

// - Runs multi-bit shifts and rotates (SHR/SHL/SAR/ROR/ROL/RCL/RCR) as N single-bit ALU passes.
// - Each pass feeds the registered result and flags back into the ALU.
// - Sits between the microcode engine and the ALU: owns the ALU a/op/flags/shift inputs while busy.
// - Returns the final result and flags with a one-cycle done pulse.

---
 rtl/shift_sequencer_pkg.sv | 35 +++
 rtl/shift_sequencer.sv | 114 +++++++++++
 tb/tb_shift_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_sequencer_pkg.sv
// Shared types for the shift sequencer: ALU op encodings,
// sequencer states and the shift-op classifier.
package shift_sequencer_pkg;

  localparam int MC_ALUOp_t_BITS = 5;
  localparam int SHIFT_COUNT_W = 5;

  typedef logic [MC_ALUOp_t_BITS-1:0] mc_aluop_t;

  localparam mc_aluop_t ALUOp_ADD = 5'd0;
  localparam mc_aluop_t ALUOp_SUB = 5'd1;
  localparam mc_aluop_t ALUOp_AND = 5'd2;
  localparam mc_aluop_t ALUOp_OR  = 5'd3;
  localparam mc_aluop_t ALUOp_XOR = 5'd4;
  localparam mc_aluop_t ALUOp_SHR = 5'd8;
  localparam mc_aluop_t ALUOp_SHL = 5'd9;
  localparam mc_aluop_t ALUOp_SAR = 5'd10;
  localparam mc_aluop_t ALUOp_ROR = 5'd11;
  localparam mc_aluop_t ALUOp_ROL = 5'd12;
  localparam mc_aluop_t ALUOp_RCL = 5'd13;
  localparam mc_aluop_t ALUOp_RCR = 5'd14;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } seq_state_t;

  function automatic logic is_shift_op(mc_aluop_t op);
    return op inside {ALUOp_SHR, ALUOp_SHL, ALUOp_SAR,
                      ALUOp_ROR, ALUOp_ROL, ALUOp_RCL,
                      ALUOp_RCR};
  endfunction

endpackage

// File: rtl/shift_sequencer.sv
// Multi-bit shift/rotate sequencer: drives the ALU one bit
// per cycle, feeding each registered result back as operand.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int COUNT_WIDTH = 5,
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic                       flush,
  input  logic [MC_ALUOp_t_BITS-1:0] op,
  input  logic                       is_8_bit,
  input  logic [WIDTH-1:0]           operand,
  input  logic [COUNT_WIDTH-1:0]     count,
  input  logic [15:0]                flags_in,
  output logic                       busy,
  output logic                       done,
  output logic                       bad_op,
  output logic [WIDTH-1:0]           result,
  output logic [15:0]                flags_out,
  output logic [WIDTH-1:0]           alu_a,
  output logic [MC_ALUOp_t_BITS-1:0] alu_op,
  output logic                       alu_is_8_bit,
  output logic [15:0]                alu_flags_in,
  output logic [4:0]                 alu_shift_count,
  output logic                       alu_multibit_shift,
  input  logic [WIDTH-1:0]           alu_out,
  input  logic [15:0]                alu_flags_out
);

  seq_state_t state, state_nx;

  logic [WIDTH-1:0]       work_r;
  logic [15:0]            flags_r;
  logic [COUNT_WIDTH-1:0] rem_r;
  mc_aluop_t              op_r;
  logic                   is8_r;
  logic                   bad_r;

  logic launch;
  assign launch = (state == ST_IDLE) && start && !flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:
          if (start)
            state_nx = (count == '0 || !is_shift_op(op))
                     ? ST_DONE : ST_RUN;
        ST_RUN:
          if (rem_r == COUNT_WIDTH'(1)) state_nx = ST_DONE;
        ST_DONE: state_nx = ST_IDLE;
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // RUN is only entered with rem_r >= 1, so the decrement never wraps
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      work_r  <= '0;
      flags_r <= '0;
      rem_r   <= '0;
      op_r    <= '0;
      is8_r   <= 1'b0;
      bad_r   <= 1'b0;
    end else if (launch) begin
      work_r  <= operand;
      flags_r <= flags_in;
      rem_r   <= count;
      op_r    <= op;
      is8_r   <= is_8_bit;
      bad_r   <= !is_shift_op(op);
    end else if (state == ST_RUN && !flush) begin
      work_r  <= alu_out;
      flags_r <= alu_flags_out;
      rem_r   <= rem_r - COUNT_WIDTH'(1);
    end
  end

  always_comb begin
    busy      = (state != ST_IDLE);
    done      = 1'b0;
    bad_op    = 1'b0;
    result    = '0;
    flags_out = '0;
    if (state == ST_DONE && !flush) begin
      done      = 1'b1;
      bad_op    = bad_r;
      flags_out = flags_r;
      result    = is8_r
                ? {{(WIDTH-8){1'b0}}, work_r[7:0]}
                : work_r;
    end
  end

  assign alu_a              = work_r;
  assign alu_op             = op_r;
  assign alu_is_8_bit       = is8_r;
  assign alu_flags_in       = flags_r;
  assign alu_shift_count    = SHIFT_COUNT_W'(1);
  assign alu_multibit_shift = 1'b0;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer with a one-bit ALU
// model and a whole-shift arithmetic reference.
module tb_shift_sequencer;
  import shift_sequencer_pkg::*;

  logic        clk = 0;
  logic        reset_n = 0;
  logic        start = 0;
  logic        flush = 0;
  mc_aluop_t   op = '0;
  logic        is_8_bit = 0;
  logic [15:0] operand = '0;
  logic [4:0]  count = '0;
  logic [15:0] flags_in = '0;
  logic        busy, done, bad_op;
  logic [15:0] result, flags_out;
  logic [15:0] alu_a, alu_flags_in;
  mc_aluop_t   alu_op;
  logic        alu_is_8_bit;
  logic [4:0]  alu_shift_count;
  logic        alu_multibit_shift;
  logic [15:0] alu_out, alu_flags_out;

  shift_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .flush(flush), .op(op), .is_8_bit(is_8_bit),
    .operand(operand), .count(count),
    .flags_in(flags_in), .busy(busy), .done(done),
    .bad_op(bad_op), .result(result),
    .flags_out(flags_out), .alu_a(alu_a),
    .alu_op(alu_op), .alu_is_8_bit(alu_is_8_bit),
    .alu_flags_in(alu_flags_in),
    .alu_shift_count(alu_shift_count),
    .alu_multibit_shift(alu_multibit_shift),
    .alu_out(alu_out), .alu_flags_out(alu_flags_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] res;
    logic [15:0] flg;
    logic        bad;
    int          at;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Single-bit ALU; only CF (bit 0) is touched.
  function automatic logic [31:0] alu_step(
      logic [15:0] a, mc_aluop_t o, logic b8, logic [15:0] f);
    int w;
    logic [15:0] m, v, r;
    logic msb, c;
    w = b8 ? 8 : 16;
    m = b8 ? 16'h00ff : 16'hffff;
    v = a & m;
    msb = b8 ? a[7] : a[15];
    r = v;
    c = f[0];
    case (o)
      ALUOp_SHL: begin r = (v << 1) & m; c = msb; end
      ALUOp_SHR: begin r = v >> 1; c = v[0]; end
      ALUOp_SAR: begin
        r = (v >> 1) | (16'(msb) << (w - 1)); c = v[0];
      end
      ALUOp_ROL: begin r = ((v << 1) | 16'(msb)) & m; c = msb; end
      ALUOp_ROR: begin
        r = (v >> 1) | (16'(v[0]) << (w - 1)); c = v[0];
      end
      ALUOp_RCL: begin r = ((v << 1) | 16'(f[0])) & m; c = msb; end
      ALUOp_RCR: begin
        r = (v >> 1) | (16'(f[0]) << (w - 1)); c = v[0];
      end
      default: ;
    endcase
    return {f[15:1], c, r};
  endfunction

  assign {alu_flags_out, alu_out} =
    alu_step(alu_a, alu_op, alu_is_8_bit, alu_flags_in);

  // Whole-shift reference computed in one step.
  task automatic ref_model(mc_aluop_t o, logic b8,
      logic [15:0] v16, logic [4:0] n5, logic [15:0] f,
      output logic [15:0] res, output logic [15:0] flg,
      output logic bad);
    longint unsigned x, m, e, ring, rm, rr;
    logic signed [63:0] sx;
    int w, n, k, W;
    logic c;
    w = b8 ? 8 : 16;
    m = b8 ? 64'hff : 64'hffff;
    x = longint'(v16) & m;
    n = int'(n5);
    bad = !(o inside {ALUOp_SHR, ALUOp_SHL, ALUOp_SAR,
                      ALUOp_ROR, ALUOp_ROL, ALUOp_RCL,
                      ALUOp_RCR});
    res = 16'(x);
    flg = f;
    if (bad || n == 0) return;
    sx = b8 ? {{56{v16[7]}}, v16[7:0]}
            : {{48{v16[15]}}, v16[15:0]};
    W = w + 1;
    ring = (longint'(f[0]) << w) | x;
    rm = (64'd1 << W) - 1;
    e = x;
    c = f[0];
    case (o)
      ALUOp_SHL: begin
        e = x << n; c = e[w]; e = e & m;
      end
      ALUOp_SHR: begin
        c = x[n-1]; e = x >> n;
      end
      ALUOp_SAR: begin
        c = sx[n-1]; e = longint'(sx >>> n) & m;
      end
      ALUOp_ROL: begin
        k = n % w;
        e = ((x << k) | (x >> (w - k))) & m; c = e[0];
      end
      ALUOp_ROR: begin
        k = n % w;
        e = ((x >> k) | (x << (w - k))) & m; c = e[w-1];
      end
      ALUOp_RCL: begin
        k = n % W;
        rr = ((ring << k) | (ring >> (W - k))) & rm;
        e = rr & m; c = rr[w];
      end
      ALUOp_RCR: begin
        k = n % W;
        rr = ((ring >> k) | (ring << (W - k))) & rm;
        e = rr & m; c = rr[w];
      end
      default: ;
    endcase
    res = 16'(e);
    flg = {f[15:1], c};
  endtask

  always @(negedge clk) begin
    if (reset_n && done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected none",
                 cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result", 32'(result), 32'(e.res));
        chk("flags_out", 32'(flags_out), 32'(e.flg));
        chk("bad_op", 32'(bad_op), 32'(e.bad));
        chk("done_cycle", 32'(cyc), 32'(e.at));
      end
    end
  end

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (busy) begin
      n_checks++;
      n_err++;
      $display("FAIL idle_timeout: got busy=1 expected 0");
    end
  endtask

  task automatic launch(mc_aluop_t o, logic b8,
      logic [15:0] v, logic [4:0] n, logic [15:0] f,
      bit expect_done);
    exp_t e;
    wait_idle();
    op = o; is_8_bit = b8; operand = v;
    count = n; flags_in = f; start = 1;
    if (expect_done) begin
      ref_model(o, b8, v, n, f, e.res, e.flg, e.bad);
      e.at = cyc + ((e.bad || n == 0) ? 1 : int'(n) + 1);
      exp_q.push_back(e);
    end
    @(negedge clk);
    start = 0;
  endtask

  task automatic pulse_start();
    op = ALUOp_SHL; operand = 16'hbeef;
    count = 5'd2; flags_in = 16'h0; start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || busy) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending expected 0",
               exp_q.size());
    end
  endtask

  initial begin
    mc_aluop_t ops[8];
    ops = '{ALUOp_SHR, ALUOp_SHL, ALUOp_SAR, ALUOp_ROR,
            ALUOp_ROL, ALUOp_RCL, ALUOp_RCR, ALUOp_ADD};
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_result", 32'(result), 0);
    chk("reset_flags", 32'(flags_out), 0);
    reset_n = 1;
    @(negedge clk);
    chk("shift_count_const", 32'(alu_shift_count), 1);
    chk("multibit_const", 32'(alu_multibit_shift), 0);

    launch(ALUOp_SHL, 0, 16'h0001, 5'd4, 16'h0001, 1);
    launch(ALUOp_RCR, 1, 16'h0001, 5'd1, 16'h0000, 1);
    launch(ALUOp_ROL, 1, 16'h0081, 5'd9, 16'h0000, 1);
    launch(ALUOp_SAR, 0, 16'h8000, 5'd0, 16'h0001, 1);
    launch(ALUOp_ADD, 0, 16'h1234, 5'd3, 16'h0040, 1);
    drain();

    // flush mid-run, then a clean restart
    launch(ALUOp_SHR, 0, 16'hf00f, 5'd8, 16'h0, 0);
    @(negedge clk);
    flush = 1;
    @(negedge clk);
    flush = 0;
    chk("flush_busy", 32'(busy), 0);
    launch(ALUOp_SHR, 0, 16'hf00f, 5'd8, 16'h0, 1);
    drain();

    // flush and start together in IDLE: no launch
    op = ALUOp_SHL; count = 5'd3; start = 1; flush = 1;
    @(negedge clk);
    start = 0; flush = 0;
    chk("flush_start_busy", 32'(busy), 0);

    // asynchronous reset mid-run
    launch(ALUOp_ROR, 0, 16'h1357, 5'd10, 16'h8001, 0);
    repeat (2) @(negedge clk);
    reset_n = 0;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_alu_a", 32'(alu_a), 0);
    chk("rst_alu_flags", 32'(alu_flags_in), 0);
    @(negedge clk);
    reset_n = 1;
    repeat (3) @(negedge clk);
    chk("rst_release_busy", 32'(busy), 0);
    launch(ALUOp_ROR, 0, 16'h1357, 5'd10, 16'h8001, 1);
    drain();

    // start while busy is ignored
    launch(ALUOp_RCL, 0, 16'ha5a5, 5'd6, 16'h0001, 1);
    @(negedge clk);
    pulse_start();
    drain();
    chk("busy_start_idle", 32'(busy), 0);

    for (int i = 0; i < 60; i++) begin
      launch(ops[$urandom_range(0, 7)], 1'($urandom),
             16'($urandom), 5'($urandom),
             16'($urandom), 1);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
